// File: rtl/vec3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec3_pkg
// Purpose  : Shared types and helpers for the vec3 assembler.
//            - WIDTH   : default IEEE-754 single-precision word width
//            - VEC_LEN : elements per vector (x, y, z)
//            - word_t, vec3_t, idx_t type definitions
//            - is_nonfinite() : exponent field all-ones (NaN / Inf)
// Revision : 1.0 - initial release
// ============================================================================
package vec3_pkg;

    localparam int WIDTH   = 32;
    localparam int VEC_LEN = 3;

    typedef logic [WIDTH-1:0]       word_t;
    typedef word_t [VEC_LEN-1:0]    vec3_t;
    typedef logic [1:0]             idx_t;

    // Exponent field of a binary32 word is bits [30:23].
    function automatic logic is_nonfinite(input word_t w);
        return (w[30:23] == 8'hFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec3_queue.sv
`default_nettype none
// ============================================================================
// Module   : vec3_queue
// Purpose  : Two-entry queue of assembled 3-element vectors.
// Ports    : clk, rst_n (async active-low), flush (sync clear),
//            push / push_data : write a vector (ignored when full),
//            pop              : drop the head entry (ignored when empty),
//            rd_data          : head entry, or last popped entry when empty,
//            count            : occupancy 0..2, full : count == 2.
// Revision : 1.0 - initial release
// ============================================================================
module vec3_queue
    import vec3_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [VEC_LEN-1:0][WIDTH-1:0] push_data,
    input  logic                        pop,
    output logic [VEC_LEN-1:0][WIDTH-1:0] rd_data,
    output idx_t                        count,
    output logic                        full
);

    logic [VEC_LEN-1:0][WIDTH-1:0] r_entry [2];
    logic                          r_wr_ptr;
    logic                          r_rd_ptr;
    idx_t                          r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == 2'd0);
    assign full    = (r_count == 2'd2);
    assign count   = r_count;

    // Overwrite and underflow are impossible by construction.
    assign w_push = push && !full;
    assign w_pop  = pop && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else if (flush) begin
            // Zeroing the storage makes the idle output read as zero.
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_push) begin
                r_entry[r_wr_ptr] <= push_data;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // When empty, the read pointer has already moved past the last popped
    // entry, which is still intact in the other slot.
    assign rd_data = r_entry[w_empty ? ~r_rd_ptr : r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vec3_assembler.sv
`default_nettype none
// ============================================================================
// Module   : vec3_assembler
// Purpose  : Collects a serial x, y, z stream of binary32 words into 3-element
//            vectors, buffers up to two of them and presents them with
//            valid/ready. Checks framing against in_last.
// Ports    : clk, rst_n (async active-low), flush (sync clear),
//            in_data / in_valid / in_last / in_ready : input word stream,
//            vec_out / out_valid / out_ready         : vector output,
//            frame_err : 1-cycle pulse per framing violation,
//            err_cnt   : saturating violation count,
//            nan_flag  : sticky non-finite input flag.
// Options  : VEC3_ASM_NAN_ZERO_EN - replace accepted NaN/Inf words by +0.0
//            and raise nan_flag; otherwise words pass through and nan_flag=0.
// Revision : 1.0 - initial release
// ============================================================================
module vec3_assembler
    import vec3_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [VEC_LEN-1:0][WIDTH-1:0] vec_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic [ERR_CNT_W-1:0]          err_cnt,
    output logic                          nan_flag
);

    localparam logic [ERR_CNT_W-1:0] c_err_max = '1;
    localparam idx_t                 c_idx_z   = 2'd2;

    idx_t                   r_idx;
    logic [WIDTH-1:0]       r_asm [2];
    logic                   r_active;
    logic                   r_frame_err;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic [WIDTH-1:0]              w_word;
    logic                          w_accept;
    logic                          w_idx_z;
    logic                          w_violation;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_q_full;
    idx_t                          w_q_count;
    logic [VEC_LEN-1:0][WIDTH-1:0] w_push_vec;

    assign w_idx_z = (r_idx == c_idx_z);

    // Only registered state feeds in_ready; r_active holds it low while in
    // reset and until the first clock edge afterwards.
    assign in_ready = r_active && (!w_idx_z || !w_q_full);

    // Words offered during a flush cycle are discarded.
    assign w_accept = in_valid && in_ready && !flush;

    // in_last must coincide exactly with the z word.
    assign w_violation = w_idx_z ? !in_last : in_last;

`ifdef VEC3_ASM_NAN_ZERO_EN
    logic w_nonfinite;
    logic r_nan_flag;

    assign w_nonfinite = is_nonfinite(word_t'(in_data));
    // Whole word cleared, sign included, so a later negation gives -0.0 only.
    assign w_word      = w_nonfinite ? '0 : in_data;
    assign nan_flag    = r_nan_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nan_flag <= 1'b0;
        end else if (w_accept && w_nonfinite) begin
            r_nan_flag <= 1'b1;
        end
    end
`else
    assign w_word   = in_data;
    assign nan_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 2'd0;
            r_asm[0]    <= '0;
            r_asm[1]    <= '0;
            r_active    <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_active    <= 1'b1;
            r_frame_err <= w_accept && w_violation;

            if (flush) begin
                r_idx <= 2'd0;
            end else if (w_accept) begin
                if (w_idx_z || in_last) begin
                    // Either the vector is committed to the queue or an early
                    // in_last discards the partial one; both restart at x.
                    r_idx <= 2'd0;
                end else begin
                    r_asm[r_idx[0]] <= w_word;
                    r_idx           <= r_idx + 2'd1;
                end
            end

            if (w_accept && w_violation && (r_err_cnt != c_err_max)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    // The z word is committed even without in_last; only the error is flagged.
    assign w_push     = w_accept && w_idx_z;
    assign w_push_vec = {w_word, r_asm[1], r_asm[0]};
    assign w_pop      = out_valid && out_ready;

    vec3_queue #(
        .WIDTH (WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_push),
        .push_data (w_push_vec),
        .pop       (w_pop),
        .rd_data   (vec_out),
        .count     (w_q_count),
        .full      (w_q_full)
    );

    assign out_valid = (w_q_count != 2'd0);
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
